// File: rtl/alu_dsp48_arbiter.sv
// alu_dsp48_arbiter: round-robin arbiter and issue sequencer that shares one
// AluDsp48 datapath among NUM_REQ requesters. Compact 4-bit opcodes are decoded
// into DSP opmode/alumode/setinst. A tag pipeline of depth LATENCY+1 follows
// each issued operation so its result is steered back to the requester.
// Optional feature: define ALU_ARB_LATENCY_CHECK_EN to build the sticky
// latency-mismatch checker driving lat_err (tied to 0 otherwise).
module alu_dsp48_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int W       = 16,
    parameter int LATENCY = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [4*NUM_REQ-1:0] req_op,
    input  logic [W*NUM_REQ-1:0] req_a,
    input  logic [W*NUM_REQ-1:0] req_b,
    input  logic [NUM_REQ-1:0]   req_cin,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [W-1:0]         rsp_data,
    output logic                 rsp_carry,
    output logic                 rsp_err,
    output logic                 lat_err,
    output logic [W-1:0]         alu_in0,
    output logic [W-1:0]         alu_in1,
    output logic                 alu_carryin,
    output logic [8:0]           alu_opmode,
    output logic [3:0]           alu_alumode,
    output logic [1:0]           alu_setinst,
    output logic                 alu_valid_in,
    input  logic [W-1:0]         alu_out,
    input  logic                 alu_carryout,
    input  logic                 alu_valid_out
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Per-requester views of the packed request buses
    logic [3:0]   op_arr [NUM_REQ];
    logic [W-1:0] a_arr  [NUM_REQ];
    logic [W-1:0] b_arr  [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op_arr[gi] = req_op[4*gi +: 4];
            assign a_arr[gi]  = req_a[W*gi +: W];
            assign b_arr[gi]  = req_b[W*gi +: W];
        end
    endgenerate

    logic [IW-1:0] ptr_reg;
    logic [IW-1:0] ptr_next;
    logic [IW-1:0] grant_idx;
    logic          grant_found;
    logic          accept;

    // Round-robin search: first valid requester at or after ptr, wrapping
    always_comb begin : p_arb
        int            cand;
        logic [IW-1:0] cand_idx;
        cand        = 0;
        cand_idx    = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_reg) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = cand[IW-1:0];
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // A grant is only offered while enabled and out of reset
    assign accept = en & reset_n & grant_found;

    // One-hot ready on the selected requester
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Priority moves just past the last granted requester
    always_comb begin
        ptr_next = ptr_reg;
        if (accept) begin
            ptr_next = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    logic [3:0]   sel_op;
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;
    logic         sel_cin;

    assign sel_op  = op_arr[grant_idx];
    assign sel_a   = a_arr[grant_idx];
    assign sel_b   = b_arr[grant_idx];
    assign sel_cin = req_cin[grant_idx];

    logic [8:0] dec_opmode;
    logic [3:0] dec_alumode;
    logic [1:0] dec_setinst;
    logic       dec_carryin;
    logic       dec_legal;

    // Opcode decode into DSP controls; compares reuse the subtract alumode
    always_comb begin
        dec_opmode  = 9'b000110011;
        dec_alumode = 4'b0000;
        dec_setinst = 2'b00;
        dec_carryin = 1'b0;
        dec_legal   = 1'b1;
        case (sel_op)
            4'd0: dec_alumode = 4'b1100;
            4'd1: begin
                dec_opmode  = 9'b000111011;
                dec_alumode = 4'b1100;
            end
            4'd2: dec_alumode = 4'b0100;
            4'd3: dec_alumode = 4'b0000;
            4'd4: dec_carryin = sel_cin;
            4'd5: dec_alumode = 4'b0011;
            4'd6: begin
                dec_alumode = 4'b0011;
                dec_setinst = 2'b01;
            end
            4'd7: begin
                dec_alumode = 4'b0011;
                dec_setinst = 2'b10;
            end
            4'd8: begin
                dec_alumode = 4'b0011;
                dec_setinst = 2'b11;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    logic [W-1:0] in0_reg;
    logic [W-1:0] in1_reg;
    logic         carryin_reg;
    logic [8:0]   opmode_reg;
    logic [3:0]   alumode_reg;
    logic [1:0]   setinst_reg;
    logic         valid_in_reg;

    // Issue register: operands zeroed on idle/illegal slots, modes hold
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in0_reg      <= '0;
            in1_reg      <= '0;
            carryin_reg  <= 1'b0;
            opmode_reg   <= '0;
            alumode_reg  <= '0;
            setinst_reg  <= '0;
            valid_in_reg <= 1'b0;
        end else if (accept && dec_legal) begin
            in0_reg      <= sel_a;
            in1_reg      <= sel_b;
            carryin_reg  <= dec_carryin;
            opmode_reg   <= dec_opmode;
            alumode_reg  <= dec_alumode;
            setinst_reg  <= dec_setinst;
            valid_in_reg <= 1'b1;
        end else begin
            in0_reg      <= '0;
            in1_reg      <= '0;
            carryin_reg  <= 1'b0;
            valid_in_reg <= 1'b0;
        end
    end

    assign alu_in0      = in0_reg;
    assign alu_in1      = in1_reg;
    assign alu_carryin  = carryin_reg;
    assign alu_opmode   = opmode_reg;
    assign alu_alumode  = alumode_reg;
    assign alu_setinst  = setinst_reg;
    assign alu_valid_in = valid_in_reg;

    logic [LATENCY:0]         tag_valid_reg;
    logic [LATENCY:0][IW-1:0] tag_idx_reg;
    logic [LATENCY:0]         tag_ill_reg;

    // Tag shift register; stage LATENCY lines up with alu_valid_out
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_valid_reg <= '0;
            tag_idx_reg   <= '0;
            tag_ill_reg   <= '0;
        end else begin
            tag_valid_reg[0] <= accept;
            tag_idx_reg[0]   <= grant_idx;
            tag_ill_reg[0]   <= ~dec_legal;
            for (int s = 1; s <= LATENCY; s++) begin
                tag_valid_reg[s] <= tag_valid_reg[s-1];
                tag_idx_reg[s]   <= tag_idx_reg[s-1];
                tag_ill_reg[s]   <= tag_ill_reg[s-1];
            end
        end
    end

    logic          tail_valid;
    logic [IW-1:0] tail_idx;
    logic          tail_ill;

    assign tail_valid = tag_valid_reg[LATENCY];
    assign tail_idx   = tag_idx_reg[LATENCY];
    assign tail_ill   = tag_ill_reg[LATENCY];

    // Response steering from the tail entry; illegal ops return zeros
    always_comb begin
        rsp_valid = '0;
        if (tail_valid) begin
            rsp_valid[tail_idx] = 1'b1;
        end
        rsp_data  = tail_ill ? '0 : alu_out;
        rsp_carry = tail_ill ? 1'b0 : alu_carryout;
        rsp_err   = tail_valid & tail_ill;
    end

`ifdef ALU_ARB_LATENCY_CHECK_EN
    localparam int MW = $clog2(LATENCY + 2);

    logic [MW-1:0] mask_cnt_reg;
    logic          lat_err_reg;

    // Sticky check that DSP valid_out tracks the expected tag tail
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mask_cnt_reg <= MW'(LATENCY + 1);
            lat_err_reg  <= 1'b0;
        end else if (mask_cnt_reg != '0) begin
            mask_cnt_reg <= mask_cnt_reg - 1'b1;
        end else if (alu_valid_out != (tail_valid & ~tail_ill)) begin
            lat_err_reg <= 1'b1;
        end
    end

    assign lat_err = lat_err_reg;
`else
    logic unused_valid_out;
    assign unused_valid_out = alu_valid_out;
    assign lat_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_dsp48_arbiter.sv
// Directed bench for alu_dsp48_arbiter with a behavioural 2-cycle DSP stand-in.
module tb_alu_dsp48_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic           clock = 1'b0;
    logic           reset_n = 1'b1;
    logic           en = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [4*N-1:0] req_op = '0;
    logic [W*N-1:0] req_a = '0;
    logic [W*N-1:0] req_b = '0;
    logic [N-1:0]   req_cin = '0;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           rsp_carry;
    logic           rsp_err;
    logic           lat_err;
    logic [W-1:0]   alu_in0;
    logic [W-1:0]   alu_in1;
    logic           alu_carryin;
    logic [8:0]     alu_opmode;
    logic [3:0]     alu_alumode;
    logic [1:0]     alu_setinst;
    logic           alu_valid_in;
    logic [W-1:0]   alu_out;
    logic           alu_carryout;
    logic           alu_valid_out;

    int total = 0;
    int bad = 0;
    logic extra_vo = 1'b0;

    alu_dsp48_arbiter #(.NUM_REQ(N), .W(W), .LATENCY(2)) dut (
        .clock(clock), .reset_n(reset_n), .en(en),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_carry(rsp_carry),
        .rsp_err(rsp_err), .lat_err(lat_err),
        .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_carryin(alu_carryin),
        .alu_opmode(alu_opmode), .alu_alumode(alu_alumode),
        .alu_setinst(alu_setinst), .alu_valid_in(alu_valid_in),
        .alu_out(alu_out), .alu_carryout(alu_carryout),
        .alu_valid_out(alu_valid_out)
    );

    always #5 clock = ~clock;

    // Behavioural DSP: {carry, result} from the issued controls
    function automatic logic [W:0] dsp_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin, input logic [8:0] opm,
                                             input logic [3:0] alum, input logic [1:0] seti);
        logic [W:0] s;
        s = '0;
        case (seti)
            2'b01: s = {{W{1'b0}}, (a == b)};
            2'b10: s = {{W{1'b0}}, (a < b)};
            2'b11: s = {{W{1'b0}}, ($signed(a) < $signed(b))};
            default: begin
                case (alum)
                    4'b1100: s = opm[3] ? {1'b0, a | b} : {1'b0, a & b};
                    4'b0100: s = {1'b0, a ^ b};
                    4'b0000: s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                    4'b0011: begin
                        s = {1'b0, a} - {1'b0, b};
                        s[W] = ~s[W];
                    end
                    default: s = '0;
                endcase
            end
        endcase
        return s;
    endfunction

    logic [W:0] d1_r = '0, d2_r = '0;
    logic       d1_v = 1'b0, d2_v = 1'b0;

    // Two-stage DSP pipeline; deliberately never reset
    always @(posedge clock) begin
        d1_v <= alu_valid_in;
        d1_r <= dsp_model(alu_in0, alu_in1, alu_carryin, alu_opmode, alu_alumode, alu_setinst);
        d2_v <= d1_v;
        d2_r <= d1_r;
    end

    assign alu_out       = d2_r[W-1:0];
    assign alu_carryout  = d2_r[W];
    assign alu_valid_out = d2_v | extra_vo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic cin);
        req_op[4*i +: 4] = op;
        req_a[W*i +: W]  = a;
        req_b[W*i +: W]  = b;
        req_cin[i]       = cin;
    endtask

    // Called at posedge+1; checks mid-cycle, then advances to next posedge+1
    task automatic step(input string tag, input logic [3:0] e_ready, input logic [3:0] e_rsp,
                        input logic [W-1:0] e_data, input logic e_chk_carry,
                        input logic e_carry, input logic e_err);
        #3;
        chk({tag, " ready"}, 32'(req_ready), 32'(e_ready));
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(e_rsp));
        if (e_rsp != 4'b0000) begin
            chk({tag, " rsp_data"}, 32'(rsp_data), 32'(e_data));
            chk({tag, " rsp_err"}, 32'(rsp_err), 32'(e_err));
            if (e_chk_carry) begin
                chk({tag, " rsp_carry"}, 32'(rsp_carry), 32'(e_carry));
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        en = 1'b1;
        req_valid = 4'hF;
        #2;
        chk("rst ready", 32'(req_ready), 32'h0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst valid_in", 32'(alu_valid_in), 32'h0);
        chk("rst opmode", 32'(alu_opmode), 32'h0);
        chk("rst lat_err", 32'(lat_err), 32'h0);
        req_valid = '0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    logic [3:0]   t_op  [8] = '{4'd8, 4'd7, 4'd12, 4'd5, 4'd6, 4'd2, 4'd0, 4'd1};
    logic [W-1:0] t_a   [8] = '{16'h8000, 16'h8000, 16'h1111, 16'h0005, 16'h0055, 16'hF0F0, 16'hF0F0, 16'hF0F0};
    logic [W-1:0] t_b   [8] = '{16'h0001, 16'h0001, 16'h2222, 16'h0003, 16'h0055, 16'hFF00, 16'hFF00, 16'hFF00};
    logic [W-1:0] t_exp [8] = '{16'h0001, 16'h0000, 16'h0000, 16'h0002, 16'h0001, 16'h0FF0, 16'hF000, 16'hFFF0};
    logic         t_ill [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        #2;
        do_reset();

        // Single ADD from requester 2
        set_req(2, 4'd3, 16'h1234, 16'h0F0F, 1'b0);
        req_valid = 4'b0100;
        step("add c0", 4'b0100, 4'b0000, '0, 1'b0, 1'b0, 1'b0);
        req_valid = '0;
        chk("add valid_in", 32'(alu_valid_in), 32'h1);
        chk("add in0", 32'(alu_in0), 32'h1234);
        chk("add in1", 32'(alu_in1), 32'h0F0F);
        chk("add opmode", 32'(alu_opmode), 32'h033);
        chk("add alumode", 32'(alu_alumode), 32'h0);
        chk("add carryin", 32'(alu_carryin), 32'h0);
        step("add c1", 4'b0000, 4'b0000, '0, 1'b0, 1'b0, 1'b0);
        step("add c2", 4'b0000, 4'b0000, '0, 1'b0, 1'b0, 1'b0);
        step("add c3", 4'b0000, 4'b0100, 16'h2143, 1'b1, 1'b0, 1'b0);

        // Contention: all four ADDC 0xFFFF+0+1
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 4'd4, 16'hFFFF, 16'h0000, 1'b1);
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            logic [3:0] er, ev;
            er = (c < 4) ? 4'(1 << c) : 4'b0000;
            ev = (c >= 3 && c < 7) ? 4'(1 << (c - 3)) : 4'b0000;
            if (c == 1) chk("addc carryin", 32'(alu_carryin), 32'h1);
            step($sformatf("cont c%0d", c), er, ev, 16'h0000, 1'b1, 1'b1, 1'b0);
            if (c < 4) req_valid[c] = 1'b0;
        end

        // Fairness: requesters 1 and 3 held for 10 cycles
        set_req(1, 4'd3, 16'h0001, 16'h0001, 1'b0);
        set_req(3, 4'd3, 16'h0003, 16'h0003, 1'b0);
        for (int c = 0; c < 13; c++) begin
            logic [3:0] er, ev;
            logic [W-1:0] ed;
            int j;
            req_valid = (c < 10) ? 4'b1010 : 4'b0000;
            er = (c < 10) ? ((c % 2 == 0) ? 4'b0010 : 4'b1000) : 4'b0000;
            j = c - 3;
            ev = (j >= 0 && j < 10) ? ((j % 2 == 0) ? 4'b0010 : 4'b1000) : 4'b0000;
            ed = (ev == 4'b0010) ? 16'h0002 : 16'h0006;
            step($sformatf("fair c%0d", c), er, ev, ed, 1'b1, 1'b0, 1'b0);
        end

        // Compares, logic ops and an illegal opcode, back to back on requester 0
        do_reset();
        for (int c = 0; c < 11; c++) begin
            int j;
            if (c < 8) begin
                set_req(0, t_op[c], t_a[c], t_b[c], 1'b0);
                req_valid = 4'b0001;
            end else begin
                req_valid = 4'b0000;
            end
            if (c >= 1 && c <= 8) begin
                chk($sformatf("ops valid_in slot%0d", c - 1), 32'(alu_valid_in), 32'(!t_ill[c-1]));
            end
            if (c == 1) begin
                chk("slts setinst", 32'(alu_setinst), 32'h3);
                chk("slts alumode", 32'(alu_alumode), 32'h3);
            end
            j = (c >= 3) ? c - 3 : 0;
            step($sformatf("ops c%0d", c), (c < 8) ? 4'b0001 : 4'b0000,
                 (c >= 3) ? 4'b0001 : 4'b0000, t_exp[j], t_ill[j], 1'b0, t_ill[j]);
        end

        // en dropped after two accepts
        do_reset();
        set_req(0, 4'd3, 16'h0001, 16'h0001, 1'b0);
        set_req(1, 4'd3, 16'h0002, 16'h0002, 1'b0);
        req_valid = 4'b0011;
        step("en c0", 4'b0001, 4'b0000, '0, 1'b0, 1'b0, 1'b0);
        step("en c1", 4'b0010, 4'b0000, '0, 1'b0, 1'b0, 1'b0);
        en = 1'b0;
        step("en c2", 4'b0000, 4'b0000, '0, 1'b0, 1'b0, 1'b0);
        step("en c3", 4'b0000, 4'b0001, 16'h0002, 1'b1, 1'b0, 1'b0);
        step("en c4", 4'b0000, 4'b0010, 16'h0004, 1'b1, 1'b0, 1'b0);
        step("en c5", 4'b0000, 4'b0000, '0, 1'b0, 1'b0, 1'b0);
        step("en c6", 4'b0000, 4'b0000, '0, 1'b0, 1'b0, 1'b0);
        req_valid = '0;
        en = 1'b1;

        // Reset while an operation is inside the DSP
        do_reset();
        set_req(0, 4'd3, 16'h0001, 16'h0001, 1'b0);
        req_valid = 4'b0001;
        step("rmid c0", 4'b0001, 4'b0000, '0, 1'b0, 1'b0, 1'b0);
        req_valid = '0;
        step("rmid c1", 4'b0000, 4'b0000, '0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        step("rmid c2", 4'b0000, 4'b0000, '0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        step("rmid c3", 4'b0000, 4'b0000, '0, 1'b0, 1'b0, 1'b0);
        step("rmid c4", 4'b0000, 4'b0000, '0, 1'b0, 1'b0, 1'b0);
        step("rmid c5", 4'b0000, 4'b0000, '0, 1'b0, 1'b0, 1'b0);

`ifdef ALU_ARB_LATENCY_CHECK_EN
        // Spurious DSP valid pulse sets the sticky flag
        do_reset();
        for (int c = 0; c < 4; c++) step("lat idle", 4'b0000, 4'b0000, '0, 1'b0, 1'b0, 1'b0);
        chk("lat before", 32'(lat_err), 32'h0);
        extra_vo = 1'b1;
        step("lat pulse", 4'b0000, 4'b0000, '0, 1'b0, 1'b0, 1'b0);
        extra_vo = 1'b0;
        chk("lat set", 32'(lat_err), 32'h1);
        for (int c = 0; c < 3; c++) step("lat hold", 4'b0000, 4'b0000, '0, 1'b0, 1'b0, 1'b0);
        chk("lat sticky", 32'(lat_err), 32'h1);
        do_reset();
`else
        chk("lat_err tied", 32'(lat_err), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_dsp48_arbiter.md
# alu_dsp48_arbiter

Round-robin arbiter and sequencer that shares one `AluDsp48` instance among `NUM_REQ` requesters. It accepts compact 4-bit ALU opcodes and decodes them into the DSP's opmode/alumode/setinst controls. It issues at most one operation per cycle and tracks in-flight operations with a tag pipeline matched to the DSP latency, so each result is steered back to the requester that issued it. It sits between the compute-core requesters and the `AluDsp48` datapath.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `W`, 16: datapath width; must equal the `AluDsp48` width.
- `LATENCY`, 2: `AluDsp48` cycles from `valid_in` to `valid_out`.
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  grant enable; low blocks new grants, in-flight operations still complete.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  one-hot grant; a request is accepted when `req_valid[i] & req_ready[i]`.
- `req_op`  in  4*NUM_REQ  opcode, slice i = `[4i+3:4i]`.
- `req_a`, `req_b`  in  W*NUM_REQ  operands, slice i = `[Wi+W-1:Wi]`.
- `req_cin`  in  NUM_REQ  carry-in; used by ADDC only.
- `rsp_valid`  out  NUM_REQ  one-hot response strobe, one cycle.
- `rsp_data`  out  W  shared result bus.
- `rsp_carry`  out  1  DSP carryout for the responding operation.
- `rsp_err`  out  1  responding operation had an illegal opcode.
- `lat_err`  out  1  sticky latency-mismatch flag (see Configuration).
- `alu_in0`, `alu_in1`  out  W  DSP operands.
- `alu_carryin`  out  1  DSP carry-in.
- `alu_opmode`  out  9  DSP opmode.
- `alu_alumode`  out  4  DSP alumode.
- `alu_setinst`  out  2  DSP setinst.
- `alu_valid_in`  out  1  DSP issue strobe.
- `alu_out`  in  W  DSP result.
- `alu_carryout`  in  1  DSP carryout.
- `alu_valid_out`  in  1  DSP result valid.

## Operation
- Opcode decode, given as opmode/alumode/setinst:
  - 0 AND: 000110011/1100/00.
  - 1 OR: 000111011/1100/00.
  - 2 XOR: 000110011/0100/00.
  - 3 ADD: 000110011/0000/00.
  - 4 ADDC: as ADD, plus carryin = `req_cin`.
  - 5 SUB: 000110011/0011/00.
  - 6 SEQ: 0011/01.
  - 7 SLTU: 0011/10.
  - 8 SLTS: 0011/11.
- Operand mapping: `alu_in0` = `req_a`, `alu_in1` = `req_b`. SUB computes a-b. SEQ/SLTU/SLTS return 0 or 1.
- `alu_carryin` is 0 for every opcode except ADDC.
- Opcodes 9..15 are illegal:
  - The request is still accepted.
  - `alu_valid_in` stays 0 for that issue slot.
  - The response arrives at normal latency with `rsp_data` = 0, `rsp_carry` = 0, `rsp_err` = 1.
- Arbitration:
  - A round-robin pointer `ptr` (reset 0) gives priority to the first valid requester at or after `ptr`, modulo `NUM_REQ`.
  - `req_ready` is combinational: one-hot on that requester when `en` = 1, else all 0.
  - After a grant to i, `ptr` becomes (i+1) mod `NUM_REQ`. Without a grant, `ptr` holds.
- Issue register: all `alu_*` outputs are registered. Non-issue cycles drive operands, carryin and `alu_valid_in` to 0; opmode/alumode/setinst hold their last value.
- Tag pipeline:
  - Depth `LATENCY`+1.
  - Each entry holds {valid, requester index, illegal bit}.
  - An entry is inserted on every accept and shifts every cycle.
- Response path:
  - `rsp_valid[idx]` = tail.valid, gated to requester idx.
  - `rsp_data` and `rsp_carry` = `alu_out` and `alu_carryout`, or 0 when the tail entry is illegal.
  - Responses are combinational from the tail entry. `rsp_data` is don't-care when no response is valid.
- No response backpressure: requesters must sink the response in the cycle it is strobed.
- Reset values: `req_ready` 0, `rsp_valid` 0, `rsp_err` 0, all `alu_*` 0, `lat_err` 0, tag pipeline empty, `ptr` 0.

## Timing
- Accept at edge t → `alu_valid_in` high in cycle t+1 → `rsp_valid` high in cycle t+1+`LATENCY` (t+3 by default).
- Throughput: one accept per cycle. Back-to-back accepts produce back-to-back responses in issue order.
- Simultaneous requests: exactly one grant per cycle; the others wait, holding their `req_*` stable.
- Dropping `en` mid-stream: no new grants; responses for the already-accepted operations still appear on schedule.
- Reset asserted mid-operation: the tag pipeline clears immediately and in-flight results are discarded. Stale `alu_valid_out` after reset never produces `rsp_valid`.
- `ptr` wrap: after a grant to `NUM_REQ`-1, priority returns to requester 0.

## Configuration
- `ALU_ARB_LATENCY_CHECK_EN` defined:
  - Each cycle, compare `alu_valid_out` with (tail.valid & ~tail.illegal).
  - Any mismatch sets `lat_err`, which is sticky until reset.
  - The check is masked for `LATENCY`+1 cycles after reset deasserts.
- Undefined: `lat_err` is tied to 0 and no check logic is built.

## Test plan
- Single ADD: req 2, a=0x1234, b=0x0F0F, op 3 → `rsp_valid[2]` 3 cycles after accept with `rsp_data`=0x2143, `rsp_carry`=0.
- Contention: all 4 requesters valid in the same cycle with ADDC a=0xFFFF, b=0, cin=1 → grants in order 0,1,2,3 on consecutive cycles; each response has `rsp_data`=0x0000, `rsp_carry`=1, delivered in the same order.
- Fairness: requesters 1 and 3 held valid for 10 cycles → grants alternate 1,3,1,3 with no starvation.
- Compare and illegal opcodes:
  - SLTS a=0x8000, b=0x0001 → 1.
  - SLTU with the same operands → 0.
  - Opcode 12 → `rsp_err`=1, `rsp_data`=0, and `alu_valid_in` stays low in that slot.
- `en` and reset:
  - Drop `en` after 2 accepts → 2 responses arrive and no further grants.
  - Assert `reset_n`=0 one cycle after an accept → no `rsp_valid` for that operation.
- With `ALU_ARB_LATENCY_CHECK_EN` defined, force an extra `alu_valid_out` pulse → `lat_err`=1 and it remains 1 until reset.
